regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the core's register file, with N read ports and one write port.
- Register 0 is hardwired to zero.
- Adds an optional write-to-read bypass and an integrated busy-bit scoreboard, so the pipelined RISC-V core can detect read-after-write hazards on pending destinations.
- Sits between decode/issue (reads, destination reservation) and writeback (write, busy release).

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers.
- NUM_READ, 2, number of independent read ports (1..4).

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- wr_en  in  1  writeback write enable.
- wr_addr  in  ADDR_WIDTH  writeback destination.
- wr_data  in  WIDTH  writeback data.
- iss_en  in  1  issue reserves a destination (sets busy).
- iss_addr  in  ADDR_WIDTH  destination being reserved.
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_READ*WIDTH  packed read data, same packing.
- rd_busy  out  NUM_READ  per-port hazard flag: the addressed register is reserved and not yet written back.
- busy_vec  out  DEPTH  current scoreboard bits; bit 0 always 0.
- any_busy  out  1  OR of busy_vec.

Behaviour:
- Reset: the reset is synchronous and active-high. With clear high at a clock edge:
  - all registers go to 0 and all busy bits go to 0;
  - this overrides any wr_en or iss_en in that same cycle.
  - After reset, every rd_data reads 0, rd_busy is 0, busy_vec is 0 and any_busy is 0.
- Write: on a rising edge with wr_en=1 and wr_addr≠0, the register at wr_addr takes wr_data. Writes to address 0 are discarded.
- Read: rd_data and rd_busy are combinational from rd_addr and current state, with 0-cycle latency.
  - Address 0 always returns 0 with rd_busy=0.
- Scoreboard, per register r≠0:
  - The busy bit sets at the edge when iss_en=1 and iss_addr=r.
  - It clears at the edge when wr_en=1 and wr_addr=r.
  - iss_addr=0 and wr_addr=0 have no effect on the scoreboard.
- Simultaneous issue and writeback to the same r: the busy bit ends set. The newer reservation wins; the data write still occurs.
- Writeback to a register that is not busy: the data is written and the busy bit stays 0. This is not an error.
- Issue to an already-busy register: the busy bit stays 1. There is no reservation count; one writeback releases it.
- rd_busy[k] reflects the busy bit as it stands before the current edge.
  - Without bypass: rd_busy[k] = busy[rd_addr_k].
  - With bypass: see Optional Feature.
- Multiple read ports may address the same register; each gets identical results.
- Reset asserted mid-operation (busy bits set, writes in flight): everything clears at that edge. A writeback in the same cycle is lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wr_en=1, wr_addr≠0 and rd_addr_k=wr_addr in the same cycle, rd_data[k] returns wr_data rather than the stored value, and rd_busy[k] is forced to 0.
  - Write-before-read semantics; a purely combinational path.
- Undefined:
  - rd_data[k] returns the stored value, which updates the next cycle.
  - rd_busy[k] stays 1 for a register that is being written this cycle.
  - The core must then stall one extra cycle.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH and ADDR_WIDTH;
  - the ZERO_REG address constant (0);
  - the maximum NUM_READ bound.
- One sub-module is natural: reg_scoreboard.
  - Contents: DEPTH busy bits plus set/clear/priority logic.
  - Ports: clock, clear, iss_en, iss_addr, wr_en, wr_addr, busy_vec.
  - The top level instantiates it alongside the storage array and NUM_READ read muxes, built with a generate loop.

Test Plan:
- Reset: preload x5=0xDEADBEEF, then pulse clear → next cycle rd_data(x5)=0, busy_vec=0, any_busy=0.
- Zero register: write x0=0x12345678 and issue x0 → rd_data(x0)=0, rd_busy=0, busy_vec[0]=0.
- Scoreboard: issue x7 at cycle 1 → rd_busy for x7=1 from cycle 2.
  - Writeback x7=0xA5A5A5A5 at cycle 4 → cycle 5: busy_vec[7]=0, rd_data(x7)=0xA5A5A5A5.
- Collision: issue x9 and writeback x9=0x11 in the same cycle → next cycle busy_vec[9]=1, rd_data(x9)=0x11.
- Bypass, with REGFILE_BYPASS_EN defined and x3 busy: wr x3=0x55 while reading x3 on port 0 and port 1 → both return 0x55 and rd_busy=0 that cycle.
  - With the macro undefined: both return the old value and rd_busy=1.
- Multi-port: NUM_READ=4; write x1..x4 = 1..4, then read ports addressing x4,x3,x2,x1 → rd_data packed {1,2,3,4} (port 3 in the upper bits).

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants for the register file with integrated busy-bit scoreboard.
// Holds the default data/address widths, the hardwired zero-register address
// and the upper bound on the number of read ports.
package regfile_pkg;
    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int ZERO_REG       = 0;
    localparam int MAX_NUM_READ   = 4;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// One busy bit per architectural register. Issue sets the bit for its
// destination, writeback clears it; when both target the same register in
// one cycle the newer reservation (issue) wins. Register 0 never goes busy.
// Ports:
//   clock    - rising-edge clock
//   clear    - synchronous active-high reset, clears every busy bit
//   iss_en   - issue reserves iss_addr
//   iss_addr - destination being reserved
//   wr_en    - writeback releases wr_addr
//   wr_addr  - destination being released
//   busy_vec - current busy bits, bit 0 tied low
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  iss_en,
    input  logic [ADDR_WIDTH-1:0] iss_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DEPTH-1:0]      busy_vec
);

    assign busy_vec[ZERO_REG] = 1'b0;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_busy
            logic r_busy;
            logic w_set;
            logic w_clr;

            assign w_set = iss_en && (iss_addr == ADDR_WIDTH'(gi));
            assign w_clr = wr_en  && (wr_addr  == ADDR_WIDTH'(gi));

            // Set takes priority over clear: a same-cycle reissue is the
            // newer reservation and must stay pending.
            always_ff @(posedge clock) begin
                if (clear) begin
                    r_busy <= 1'b0;
                end else if (w_set) begin
                    r_busy <= 1'b1;
                end else if (w_clr) begin
                    r_busy <= 1'b0;
                end
            end

            assign busy_vec[gi] = r_busy;
        end
    endgenerate

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with NUM_READ combinational read ports, one write port,
// hardwired-zero register 0 and an integrated busy-bit scoreboard for
// read-after-write hazard detection.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a read that hits
// the register being written this cycle returns wr_data and reports not busy.
// Ports:
//   clock, clear         - clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data - writeback port (also releases busy bit)
//   iss_en/iss_addr      - destination reservation from issue
//   rd_addr              - packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data              - packed read data, port k at [k*WIDTH +: WIDTH]
//   rd_busy              - per-port hazard flag
//   busy_vec, any_busy   - raw scoreboard bits and their OR
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                           clock,
    input  logic                           clear,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           iss_en,
    input  logic [ADDR_WIDTH-1:0]          iss_addr,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*WIDTH-1:0]      rd_data,
    output logic [NUM_READ-1:0]            rd_busy,
    output logic [DEPTH-1:0]               busy_vec,
    output logic                           any_busy
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic             w_wr_valid;

    assign w_wr_valid = wr_en && (wr_addr != ADDR_WIDTH'(ZERO_REG));

    // Storage is cleared by reset, so it stays in fabric registers rather
    // than block RAM; reads must also be asynchronous for 0-cycle latency.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_scoreboard (
        .clock    (clock),
        .clear    (clear),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    assign any_busy = |busy_vec;

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] w_addr;
            logic                  w_is_zero;

            assign w_addr    = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_is_zero = (w_addr == ADDR_WIDTH'(ZERO_REG));

`ifdef REGFILE_BYPASS_EN
            logic w_hit;
            // Write-before-read: the in-flight writeback value is visible
            // now and its destination is no longer a hazard.
            assign w_hit = w_wr_valid && (w_addr == wr_addr);
            assign rd_data[gi*WIDTH +: WIDTH] = w_is_zero ? '0      :
                                                w_hit     ? wr_data :
                                                            r_regs[w_addr];
            assign rd_busy[gi] = !w_is_zero && !w_hit && busy_vec[w_addr];
`else
            assign rd_data[gi*WIDTH +: WIDTH] = w_is_zero ? '0 : r_regs[w_addr];
            assign rd_busy[gi] = !w_is_zero && busy_vec[w_addr];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Self-checking bench for regfile_scoreboard with NUM_READ=4. A reference
// model tracks registers and busy bits; expected read results are queued when
// stimulus is driven and popped when the DUT outputs are sampled.
// Honours REGFILE_BYPASS_EN the same way as the design.
module tb_regfile_scoreboard;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int D  = 2**AW;

    logic              clock = 1'b0;
    logic              clear;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_busy;
    logic [D-1:0]      busy_vec;
    logic              any_busy;

    regfile_scoreboard #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
        .clock    (clock),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec),
        .any_busy (any_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NR*W-1:0] data;
        logic [NR-1:0]   busy;
        logic [D-1:0]    bvec;
        logic            any;
    } exp_t;

    exp_t          exp_q[$];
    logic [W-1:0]  m_regs [D];
    logic [D-1:0]  m_busy;
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_txn    = 0;

    task automatic check(input string tag, input logic [NR*W-1:0] got, input logic [NR*W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic drive(input logic clr, input logic we, input int wa, input logic [W-1:0] wd,
                         input logic ie, input int ia, input int r0, input int r1, input int r2, input int r3);
        clear    = clr;
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = AW'(ia);
        rd_addr  = {AW'(r3), AW'(r2), AW'(r1), AW'(r0)};
    endtask

    // Push the model's prediction for the currently driven inputs.
    task automatic predict();
        exp_t e;
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            if (a == '0) begin
                e.data[k*W +: W] = '0;
                e.busy[k]        = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (wr_en && wr_addr != '0 && wr_addr == a) begin
                e.data[k*W +: W] = wr_data;
                e.busy[k]        = 1'b0;
            end
`endif
            else begin
                e.data[k*W +: W] = m_regs[a];
                e.busy[k]        = m_busy[a];
            end
        end
        e.bvec = m_busy;
        e.any  = |m_busy;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: clr=%b wr=%b/%0d/%h iss=%b/%0d rd_addr=%h rd_data=%h rd_busy=%b any=%b",
                 n_txn, clear, wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr, rd_data, rd_busy, any_busy);
        check("rd_data",  rd_data,  e.data);
        check("rd_busy",  NR*W'(rd_busy),  NR*W'(e.busy));
        check("busy_vec", NR*W'(busy_vec), NR*W'(e.bvec));
        check("any_busy", NR*W'(any_busy), NR*W'(e.any));
    endtask

    // Advance one edge and update the model from the inputs seen at it.
    task automatic tick();
        @(posedge clock);
        if (clear) begin
            for (int i = 0; i < D; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (wr_en && wr_addr != '0) begin
                m_regs[wr_addr] = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic step(input logic clr, input logic we, input int wa, input logic [W-1:0] wd,
                        input logic ie, input int ia, input int r0, input int r1, input int r2, input int r3);
        drive(clr, we, wa, wd, ie, ia, r0, r1, r2, r3);
        predict();
        sample();
        tick();
    endtask

    initial begin
        drive(1, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        tick();   // first reset edge: model and DUT both cleared here

        // Reset after preloading x5
        step(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 0);
        step(0, 0, 0, '0, 1, 6, 5, 5, 0, 0);
        step(1, 1, 5, 32'h1, 1, 5, 5, 6, 0, 0);   // clear wins over wr/iss
        drive(0, 0, 0, '0, 0, 0, 5, 6, 0, 0);
        predict(); sample();
        check("reset_x5", NR*W'(rd_data[W-1:0]), '0);
        check("reset_any", NR*W'(any_busy), '0);
        tick();

        // Zero register
        step(0, 1, 0, 32'h12345678, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, '0, 0, 0, 0, 0, 0, 0);
        predict(); sample();
        check("x0_busy", NR*W'(busy_vec[0]), '0);
        tick();

        // Scoreboard set/clear on x7
        step(0, 0, 0, '0, 1, 7, 7, 0, 0, 0);
        step(0, 0, 0, '0, 0, 0, 7, 7, 0, 0);
        step(0, 0, 0, '0, 0, 0, 7, 0, 0, 0);
        step(0, 1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, 0, 0);
        drive(0, 0, 0, '0, 0, 0, 7, 0, 0, 0);
        predict(); sample();
        check("x7_data", NR*W'(rd_data[W-1:0]), NR*W'(32'hA5A5A5A5));
        check("x7_busy", NR*W'(busy_vec[7]), '0);
        tick();

        // Collision: issue and writeback x9 together
        step(0, 1, 9, 32'h11, 1, 9, 9, 0, 0, 0);
        drive(0, 0, 0, '0, 0, 0, 9, 0, 0, 0);
        predict(); sample();
        check("x9_busy", NR*W'(busy_vec[9]), NR*W'(1'b1));
        check("x9_data", NR*W'(rd_data[W-1:0]), NR*W'(32'h11));
        tick();
        step(0, 1, 9, 32'h22, 0, 0, 9, 0, 0, 0);

        // Bypass window on busy x3
        step(0, 0, 0, '0, 1, 3, 3, 3, 0, 0);
        drive(0, 1, 3, 32'h55, 0, 0, 3, 3, 0, 0);
        predict(); sample();
`ifdef REGFILE_BYPASS_EN
        check("byp_data", rd_data[2*W-1:0], {32'h55, 32'h55});
        check("byp_busy", NR*W'(rd_busy[1:0]), NR*W'(2'b00));
`else
        check("byp_data", rd_data[2*W-1:0], '0);
        check("byp_busy", NR*W'(rd_busy[1:0]), NR*W'(2'b11));
`endif
        tick();

        // Multi-port reads
        for (int i = 1; i <= 4; i++) step(0, 1, i, W'(i), 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, '0, 0, 0, 4, 3, 2, 1);
        predict(); sample();
        check("multiport", rd_data, {32'd1, 32'd2, 32'd3, 32'd4});
        tick();

        // Writeback to idle register, double issue then single release
        step(0, 1, 12, 32'hCAFE, 0, 0, 12, 0, 0, 0);
        step(0, 0, 0, '0, 1, 13, 13, 0, 0, 0);
        step(0, 0, 0, '0, 1, 13, 13, 13, 0, 0);
        step(0, 1, 13, 32'hBEEF, 0, 0, 13, 12, 0, 0);
        step(0, 0, 0, '0, 0, 0, 13, 12, 0, 0);

        // Reset mid-operation drops the in-flight writeback
        step(0, 0, 0, '0, 1, 10, 10, 0, 0, 0);
        step(1, 1, 11, 32'h777, 1, 14, 10, 11, 14, 0);
        step(0, 0, 0, '0, 0, 0, 10, 11, 14, 12);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            step(0, 1'($urandom_range(0, 1)), $urandom_range(0, D-1), $urandom,
                 1'($urandom_range(0, 1)), $urandom_range(0, D-1),
                 $urandom_range(0, D-1), $urandom_range(0, D-1),
                 $urandom_range(0, D-1), $urandom_range(0, D-1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
